soc_boot_loader: RTL and testbench
==================================

# soc_boot_loader

Byte-stream boot loader that sits directly upstream of `riscv_soc`. It receives a framed program image over a valid/ready byte interface and assembles little-endian 32-bit instruction words. It writes those words into the instruction ROM's write port and holds the core in reset until the image is fully loaded and verified. It replaces `$readmemh` preloading for synthesized builds.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: ROM word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: synchronous, active-low reset.
- `restart`  in  1: single-cycle pulse; abort or finish, then reload.
- `in_valid`  in  1: byte-stream valid.
- `in_data`  in  8: byte-stream data.
- `in_ready`  out  1: loader accepts a byte; a byte transfers when `in_valid & in_ready`.
- `rom_we`  out  1: ROM write strobe, one cycle per word.
- `rom_waddr`  out  ADDR_WIDTH: ROM word address.
- `rom_wdata`  out  32: ROM write data.
- `core_rstn`  out  1: active-low reset to `riscv_soc`.
- `done`  out  1: image loaded and accepted; sticky.
- `error`  out  1: load failed; sticky until `restart` or `rstn`.

## Operation
- Frame format: 4-byte word count N (little-endian), then N words of 4 bytes each (LSB first), then 1 checksum byte if the checksum feature is compiled in.
- States:
  - HDR: collect 4 count bytes.
  - DATA: collect word bytes.
  - CSUM: collect 1 checksum byte.
  - RUN: load complete.
  - ERR: load failed.
- State transitions:
  - HDR → DATA when the 4th header byte is accepted and 0 < N ≤ 2^ADDR_WIDTH.
  - HDR → CSUM when N == 0; with the checksum feature disabled, HDR → RUN when N == 0.
  - HDR → ERR when N > 2^ADDR_WIDTH.
  - DATA → CSUM (or RUN if the feature is disabled) when the 4th byte of word N-1 is accepted.
  - CSUM → RUN when the received byte equals the running checksum; otherwise CSUM → ERR.
- Byte and word counters:
  - A byte-lane counter (2 bits) wraps 3→0 at each completed word.
  - The word index is ADDR_WIDTH+1 bits wide, so that N = 2^ADDR_WIDTH is representable.
  - N is held as 32 bits; the over-capacity compare uses the full 32 bits.
- Checksum: 8-bit XOR of all data bytes. Header bytes are excluded. The checksum clears on entry to HDR.
- `restart` (any state) → HDR. It clears counters, checksum, `done` and `error`, and drives `core_rstn` low. `restart` takes priority over a simultaneous byte transfer, and that byte is dropped.
- In RUN and ERR, `in_ready` = 0 and incoming bytes are ignored.

## Timing
- Reset values:
  - State HDR.
  - `in_ready` 0; it asserts the first cycle after `rstn` goes high.
  - `rom_we` 0, `rom_waddr` 0, `rom_wdata` 0.
  - `core_rstn` 0, `done` 0, `error` 0.
- `in_ready` is registered:
  - It is 1 in HDR, DATA and CSUM.
  - It drops the cycle after the last byte of the frame is accepted.
  - It drops the cycle after `restart`, and re-asserts one cycle later.
- Word write latency: `rom_we` pulses for exactly 1 cycle, on the cycle after the 4th byte of a word is accepted. `rom_waddr` and `rom_wdata` are valid in the same cycle.
- Back-to-back words: the minimum spacing between `rom_we` pulses is 4 cycles; throughput is 1 byte per cycle. Gaps on `in_valid` only stall the load.
- Release timing, measured from the cycle in which RUN is entered:
  - `done` rises 1 cycle later.
  - `core_rstn` rises 2 cycles later, so that the last ROM write has completed before the core fetches from address 0.
- `error` rises 1 cycle after entering ERR. `core_rstn` stays 0 in ERR.
- Reset mid-load: the state and all outputs return to their reset values on the next edge. The partially written ROM contents are not cleared.

## Configuration
- `BOOT_LOADER_CHECKSUM_EN` defined:
  - The CSUM state and the checksum byte are present.
  - A mismatch goes to ERR.
- `BOOT_LOADER_CHECKSUM_EN` undefined:
  - No checksum byte is expected.
  - CSUM and the checksum register are compiled out.
  - The last data byte (or the header when N == 0) goes directly to RUN.

## Test plan
- Checksum enabled; stream 02 00 00 00, 13 00 00 00, 93 00 10 00, checksum 90 → writes addr 0 = 0x00000013 and addr 1 = 0x00100093; `done`=1; `core_rstn`=1 two cycles after the checksum byte's state change.
- Same image with checksum byte 91 → `error`=1, `core_rstn` stays 0, `in_ready`=0; no further writes occur after addr 1.
- N=0 header 00 00 00 00 followed by checksum byte 00 → no `rom_we`; `done`=1.
- ADDR_WIDTH=12; header 01 10 00 00 (N=4097) → ERR after the 4th header byte, with zero `rom_we` pulses.
- `restart` pulsed after 5 data bytes, with `in_valid` high in the same cycle → that byte is dropped; the state returns to HDR; `core_rstn`=0; a following full 1-word frame writes addr 0.
- Checksum disabled; stream 01 00 00 00, 13 00 00 00 → 1 write to addr 0; `done`=1 with no checksum byte; a further byte offered sees `in_ready`=0.

Source files
------------

// File: rtl/soc_boot_loader.sv
// rtl/soc_boot_loader.sv - framed byte-stream loader that fills instruction ROM and releases core reset
//
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN
//   defined   : frame ends with an 8-bit XOR checksum of all data bytes; mismatch -> ERR
//   undefined : no checksum byte; last data byte (or empty header) goes straight to RUN
//
// Frame: 4-byte LE word count N, then N LE 32-bit words, then optional checksum byte.
//
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   restart           single-cycle pulse: abort/finish and return to header collection
//   in_valid/in_data  byte stream in; in_ready out, transfer on in_valid & in_ready
//   rom_we            one-cycle write strobe per assembled word
//   rom_waddr         ROM word address (ADDR_WIDTH bits)
//   rom_wdata         assembled 32-bit word
//   core_rstn         active-low reset to the core; released 2 cycles after RUN entry
//   done              image loaded and accepted (sticky until restart/rstn)
//   error             load failed (sticky until restart/rstn)
module soc_boot_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  restart,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_waddr,
  output logic [31:0]           rom_wdata,
  output logic                  core_rstn,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
`ifdef BOOT_LOADER_CHECKSUM_EN
    S_CSUM = 3'd2,
`endif
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

  state_t                state_q;
  state_t                state_d;
  logic                  ready_en;
  logic [1:0]            lane;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [31:0]           count;
  logic [23:0]           word_buf;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic                  xfer;
  logic [31:0]           n_full;
  logic                  hdr_last;
  logic                  word_last;
  logic                  final_word;

  // restart wins over a simultaneous byte; that byte is simply not consumed
  assign xfer       = in_valid & in_ready & ~restart;
  // full count as it will be once the 4th header byte lands
  assign n_full     = {in_data, count[23:0]};
  assign hdr_last   = xfer && (state_q == S_HDR)  && (lane == 2'd3);
  assign word_last  = xfer && (state_q == S_DATA) && (lane == 2'd3);
  assign final_word = ({{(31-ADDR_WIDTH){1'b0}}, word_idx} + 32'd1) == count;

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = S_HDR;
    end else begin
      case (state_q)
        S_HDR: begin
          if (hdr_last) begin
            if (n_full == 32'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_RUN;
`endif
            end else if ({1'b0, n_full} > CAPACITY) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_last && final_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_RUN;
`endif
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            state_d = (in_data == csum) ? S_RUN : S_ERR;
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // output logic: in_ready depends only on registered state, so it behaves as a registered output.
  // ready_en holds it low for one cycle after reset release and after restart.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR, S_DATA: in_ready = ready_en;
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CSUM:        in_ready = ready_en;
`endif
      default:       in_ready = 1'b0;
    endcase
  end

  // datapath: counters, word assembly, ROM write port, status
  always_ff @(posedge clk) begin
    if (!rstn || restart) begin
      ready_en  <= 1'b0;
      lane      <= 2'd0;
      word_idx  <= '0;
      count     <= 32'd0;
      word_buf  <= 24'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= 32'd0;
      done      <= 1'b0;
      error     <= 1'b0;
      core_rstn <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      rom_we   <= 1'b0;
      if (xfer) begin
        if (state_q == S_HDR) begin
          lane <= lane + 2'd1;
          count[{lane, 3'b000} +: 8] <= in_data;
        end else if (state_q == S_DATA) begin
          lane <= lane + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
          if (lane == 2'd3) begin
            rom_we    <= 1'b1;
            rom_waddr <= word_idx[ADDR_WIDTH-1:0];
            rom_wdata <= {in_data, word_buf};
            word_idx  <= word_idx + (ADDR_WIDTH+1)'(1);
          end else begin
            word_buf[{lane, 3'b000} +: 8] <= in_data;
          end
        end
      end
      done      <= done  | (state_q == S_RUN);
      error     <= error | (state_q == S_ERR);
      // one extra stage behind done so the last ROM write settles before the core fetches
      core_rstn <= done;
    end
  end

endmodule

// File: tb/tb_soc_boot_loader.sv
// tb/tb_soc_boot_loader.sv - directed self-checking bench for soc_boot_loader
module tb_soc_boot_loader;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rstn;
  logic          restart;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          rom_we;
  logic [AW-1:0] rom_waddr;
  logic [31:0]   rom_wdata;
  logic          core_rstn;
  logic          done;
  logic          error;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int base;

  soc_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rom_we    (rom_we),
    .rom_waddr (rom_waddr),
    .rom_wdata (rom_wdata),
    .core_rstn (core_rstn),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rom_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one byte at a negedge, wait (bounded) for in_ready, return at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_rom_we",    {31'd0, rom_we},    32'd0);
    chk("rst_rom_waddr", {20'd0, rom_waddr}, 32'd0);
    chk("rst_rom_wdata", rom_wdata,          32'd0);
    chk("rst_core_rstn", {31'd0, core_rstn}, 32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_error",     {31'd0, error},     32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // two-word image
    base = we_cnt;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("w0_we",   {31'd0, rom_we},    32'd1);
    chk("w0_addr", {20'd0, rom_waddr}, 32'd0);
    chk("w0_data", rom_wdata,          32'h00000013);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    chk("w1_we",   {31'd0, rom_we},    32'd1);
    chk("w1_addr", {20'd0, rom_waddr}, 32'd1);
    chk("w1_data", rom_wdata,          32'h00100093);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_byte(8'h90);
`endif
    chk("run_ready",  {31'd0, in_ready},  32'd0);
    chk("run_done0",  {31'd0, done},      32'd0);
    @(negedge clk);
    chk("run_done1",  {31'd0, done},      32'd1);
    chk("run_crst1",  {31'd0, core_rstn}, 32'd0);
    @(negedge clk);
    chk("run_crst2",  {31'd0, core_rstn}, 32'd1);
    chk("run_writes", we_cnt - base,      32'd2);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // same image, bad checksum
    pulse_restart();
    base = we_cnt;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h91);
    @(negedge clk);
    chk("bad_error",  {31'd0, error},     32'd1);
    chk("bad_crst",   {31'd0, core_rstn}, 32'd0);
    chk("bad_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk);
    chk("bad_crst2",  {31'd0, core_rstn}, 32'd0);
    chk("bad_writes", we_cnt - base,      32'd2);
`else
    // a byte offered after completion is not accepted
    base = we_cnt;
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("post_ready",  {31'd0, in_ready}, 32'd0);
    chk("post_done",   {31'd0, done},     32'd1);
    chk("post_writes", we_cnt - base,     32'd0);
    in_valid = 1'b0;
`endif

    // empty image
    pulse_restart();
    chk("rs_done_clr", {31'd0, done}, 32'd0);
    base = we_cnt;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    @(negedge clk);
    chk("n0_done",   {31'd0, done}, 32'd1);
    chk("n0_writes", we_cnt - base, 32'd0);

    // over capacity: N = 4097
    pulse_restart();
    base = we_cnt;
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    chk("ovf_ready",  {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("ovf_error",  {31'd0, error},     32'd1);
    chk("ovf_crst",   {31'd0, core_rstn}, 32'd0);
    chk("ovf_writes", we_cnt - base,      32'd0);

    // restart mid-data with a byte offered in the same cycle
    pulse_restart();
    chk("rs_error_clr", {31'd0, error}, 32'd0);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    in_valid = 1'b1; in_data = 8'h66; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; in_valid = 1'b0;
    chk("ab_ready", {31'd0, in_ready},  32'd0);
    chk("ab_crst",  {31'd0, core_rstn}, 32'd0);
    @(negedge clk);
    chk("ab_ready2", {31'd0, in_ready}, 32'd1);
    base = we_cnt;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    chk("ab_addr", {20'd0, rom_waddr}, 32'd0);
    chk("ab_data", rom_wdata,          32'h12345678);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_byte(8'h08);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("ab_done",   {31'd0, done},      32'd1);
    chk("ab_crst2",  {31'd0, core_rstn}, 32'd1);
    chk("ab_writes", we_cnt - base,      32'd1);

    // reset in the middle of a load
    pulse_restart();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAA);
    rstn = 1'b0;
    @(negedge clk);
    chk("mr_ready", {31'd0, in_ready},  32'd0);
    chk("mr_we",    {31'd0, rom_we},    32'd0);
    chk("mr_addr",  {20'd0, rom_waddr}, 32'd0);
    chk("mr_data",  rom_wdata,          32'd0);
    chk("mr_done",  {31'd0, done},      32'd0);
    chk("mr_crst",  {31'd0, core_rstn}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("mr_ready2", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
